// File: rtl/hanoi_pkg.sv
// hanoi_pkg: shared types and width helper for the Tower of Hanoi engine
package hanoi_pkg;
    typedef enum logic [2:0] {
        OK                = 3'd0,
        BAD_PEG           = 3'd1,
        SAME_PEG          = 3'd2,
        EMPTY_SRC         = 3'd3,
        BIGGER_ON_SMALLER = 3'd4
    } move_status_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_COMMIT = 2'd2,
        S_RESP   = 2'd3
    } engine_state_t;

    function automatic int disk_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/hanoi_engine_peg_stack.sv
// hanoi_peg_stack: single-peg LIFO of disk IDs, optionally filled with the full tower at reset
// Ports: clk, rst (async active-low), push_i/disk_i push a disk, pop_i drops the top,
// top_o is the top disk (0 when empty), cnt_o the occupancy.
// With HANOI_INVARIANT_CHECK_EN defined, slots_o exposes the contents and the
// stack checks that it is strictly decreasing from bottom to top.
module hanoi_peg_stack
    import hanoi_pkg::*;
#(
    parameter int  NUM_DISKS = 4,
    parameter bit  FILL      = 1'b0,
    localparam int DISK_W    = disk_w(NUM_DISKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DISK_W-1:0] disk_i,
    output logic [DISK_W-1:0] top_o,
    output logic [DISK_W-1:0] cnt_o
`ifdef HANOI_INVARIANT_CHECK_EN
    ,
    output logic [NUM_DISKS*DISK_W-1:0] slots_o
`endif
);
    // Depth rounded up to the count range so any count value indexes safely.
    localparam int DEPTH = 1 << DISK_W;

    logic [DISK_W-1:0] stack_q [DEPTH];
    logic [DISK_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < DEPTH; s++)
                stack_q[s] <= (FILL && s < NUM_DISKS) ? DISK_W'(NUM_DISKS - s) : '0;
            cnt_q <= FILL ? DISK_W'(NUM_DISKS) : '0;
        end else begin
            if (push_i)
                stack_q[cnt_q] <= disk_i;
            cnt_q <= cnt_q + DISK_W'(push_i) - DISK_W'(pop_i);
        end
    end

    assign top_o = (cnt_q == '0) ? '0 : stack_q[cnt_q - DISK_W'(1)];
    assign cnt_o = cnt_q;

`ifdef HANOI_INVARIANT_CHECK_EN
    for (genvar s = 0; s < NUM_DISKS; s++) begin : g_slot
        assign slots_o[s*DISK_W +: DISK_W] = stack_q[s];
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 1; s < NUM_DISKS; s++)
                if (DISK_W'(s) < cnt_q)
                    assert (stack_q[s] < stack_q[s-1]);
        end
    end
`endif
endmodule

// File: rtl/hanoi_engine.sv
// hanoi_engine: parametrised Tower of Hanoi state engine with move handshake and legality check
// Ports: clk, rst (async active-low); req_valid/req_ready/req_from/req_to request a move;
// resp_valid/resp_status report its outcome one pulse later; move_count counts legal
// moves (saturating); solved flags the whole tower on the last peg; peg_top holds the
// top disk per peg, peg 0 in the LSBs, 0 for an empty peg.
// Optional macro HANOI_INVARIANT_CHECK_EN adds embedded invariant checks and covers.
module hanoi_engine
    import hanoi_pkg::*;
#(
    parameter int  NUM_DISKS = 4,
    parameter int  NUM_PEGS  = 3,
    parameter int  MOVE_W    = 16,
    localparam int DISK_W    = disk_w(NUM_DISKS),
    localparam int PEG_W     = $clog2(NUM_PEGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [PEG_W-1:0]           req_from,
    input  logic [PEG_W-1:0]           req_to,
    output logic                       resp_valid,
    output logic [2:0]                 resp_status,
    output logic [MOVE_W-1:0]          move_count,
    output logic                       solved,
    output logic [NUM_PEGS*DISK_W-1:0] peg_top
);
    localparam int LAST = NUM_PEGS - 1;

    engine_state_t     state_q;
    move_status_t      status_q, status_d;
    logic [PEG_W-1:0]  from_q, to_q;
    logic              req_ready_q, resp_valid_q, solved_q;
    logic [MOVE_W-1:0] move_count_q;

    logic [DISK_W-1:0] top [NUM_PEGS];
    logic [DISK_W-1:0] cnt [NUM_PEGS];
    logic [DISK_W-1:0] src_top, dst_top, src_cnt, dst_cnt, last_cnt_d;
    logic              commit;

`ifdef HANOI_INVARIANT_CHECK_EN
    logic [NUM_DISKS*DISK_W-1:0] slots [NUM_PEGS];
`endif

    assign commit = state_q == S_COMMIT;

    for (genvar p = 0; p < NUM_PEGS; p++) begin : g_peg
        hanoi_peg_stack #(
            .NUM_DISKS (NUM_DISKS),
            .FILL      (p == 0)
        ) u_peg (
            .clk    (clk),
            .rst    (rst),
            .push_i (commit && to_q == PEG_W'(p)),
            .pop_i  (commit && from_q == PEG_W'(p)),
            .disk_i (src_top),
            .top_o  (top[p]),
            .cnt_o  (cnt[p])
`ifdef HANOI_INVARIANT_CHECK_EN
            ,
            .slots_o(slots[p])
`endif
        );
        assign peg_top[p*DISK_W +: DISK_W] = top[p];
    end

    // Peg indices may be out of range, so select by comparison rather than indexing.
    always_comb begin
        src_top = '0;
        dst_top = '0;
        src_cnt = '0;
        dst_cnt = '0;
        for (int p = 0; p < NUM_PEGS; p++) begin
            src_top = from_q == PEG_W'(p) ? top[p] : src_top;
            src_cnt = from_q == PEG_W'(p) ? cnt[p] : src_cnt;
            dst_top = to_q == PEG_W'(p) ? top[p] : dst_top;
            dst_cnt = to_q == PEG_W'(p) ? cnt[p] : dst_cnt;
        end
    end

    always_comb begin
        status_d = ({1'b0, from_q} >= (PEG_W+1)'(NUM_PEGS) ||
                    {1'b0, to_q}   >= (PEG_W+1)'(NUM_PEGS)) ? BAD_PEG :
                   (from_q == to_q)                          ? SAME_PEG :
                   (src_cnt == '0)                           ? EMPTY_SRC :
                   (dst_cnt != '0 && src_top > dst_top)      ? BIGGER_ON_SMALLER : OK;
    end

    // Occupancy of the last peg as it will be after the committed move.
    assign last_cnt_d = cnt[LAST] + DISK_W'(to_q == PEG_W'(LAST)) - DISK_W'(from_q == PEG_W'(LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            from_q       <= '0;
            to_q         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            status_q     <= OK;
            move_count_q <= '0;
            solved_q     <= (NUM_PEGS == 1);
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    from_q      <= req_from;
                    to_q        <= req_to;
                    req_ready_q <= 1'b0;
                    state_q     <= S_CHECK;
                end
                S_CHECK: begin
                    status_q     <= status_d;
                    resp_valid_q <= status_d != OK;
                    state_q      <= status_d == OK ? S_COMMIT : S_RESP;
                end
                S_COMMIT: begin
                    move_count_q <= &move_count_q ? move_count_q : move_count_q + 1'b1;
                    solved_q     <= last_cnt_d == DISK_W'(NUM_DISKS);
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_status = status_q;
    assign move_count  = move_count_q;
    assign solved      = solved_q;

`ifdef HANOI_INVARIANT_CHECK_EN
    always @(posedge clk) begin : inv
        int sum;
        int seen [1 << DISK_W];
        if (rst) begin
            sum = 0;
            for (int d = 0; d < (1 << DISK_W); d++)
                seen[d] = 0;
            for (int p = 0; p < NUM_PEGS; p++) begin
                sum += int'(cnt[p]);
                for (int s = 0; s < NUM_DISKS; s++)
                    if (DISK_W'(s) < cnt[p])
                        seen[slots[p][s*DISK_W +: DISK_W]]++;
            end
            assert (sum == NUM_DISKS);
            for (int d = 1; d <= NUM_DISKS; d++)
                assert (seen[d] == 1);
        end
    end

    assert property (@(posedge clk) disable iff (!rst) resp_valid |=> !resp_valid);
    cover property (@(posedge clk) disable iff (!rst) solved);
    cover property (@(posedge clk) disable iff (!rst) resp_valid && resp_status == OK);
    cover property (@(posedge clk) disable iff (!rst) resp_valid && resp_status == BAD_PEG);
    cover property (@(posedge clk) disable iff (!rst) resp_valid && resp_status == SAME_PEG);
    cover property (@(posedge clk) disable iff (!rst) resp_valid && resp_status == EMPTY_SRC);
    cover property (@(posedge clk) disable iff (!rst) resp_valid && resp_status == BIGGER_ON_SMALLER);
`endif
endmodule
